// File: rtl/twos_dec_serial.sv
// twos_dec_serial: bit-serial two's-complement to sign-magnitude decoder.
// Accepts one WIDTH-bit word through a valid/ready handshake. It then walks
// the word LSB-first, one bit per clock, using copy-until-first-one-then-invert.
// The result is held until the consumer accepts it.
//
// Optional feature macro: TWOS_DEC_SAT_EN. When it is defined, the most-negative
// input saturates to 2^(WIDTH-1)-1 and sets out_sat.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready is high only in IDLE
//   in_data[WIDTH]        two's-complement operand
//   out_valid/out_ready   output handshake
//   out_sign              sign of the operand
//   out_mag[WIDTH]        unsigned magnitude
//   out_sat               most-negative input was saturated
module twos_dec_serial #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [WIDTH-1:0] out_mag,
   output logic             out_sat
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_n;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             seen;
   logic             accept_c;
   logic             last_c;
   logic             mbit_c;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state and handshake strobes
   always_comb begin
      state_n  = state;
      accept_c = 1'b0;
      last_c   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept_c = 1'b1;
               state_n  = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == LAST_CNT) begin
               last_c  = 1'b1;
               state_n = DONE;
            end
         end
         DONE: begin
            if (out_valid && out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // For a negative word, copy bits up to and including the first one, then invert.
   assign mbit_c = out_sign ? (sreg[0] ^ seen) : sreg[0];

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sign  <= 1'b0;
         out_mag   <= '0;
         out_sat   <= 1'b0;
         sreg      <= '0;
         cnt       <= '0;
         seen      <= 1'b0;
      end else begin
         in_ready  <= (state_n == IDLE);
         out_valid <= (state_n == DONE);
         if (accept_c) begin
            sreg     <= in_data;
            out_sign <= in_data[WIDTH-1];
            cnt      <= '0;
            seen     <= 1'b0;
            out_sat  <= 1'b0;
         end else if (state == SHIFT) begin
            sreg    <= sreg >> 1;
            out_mag <= {mbit_c, out_mag[WIDTH-1:1]};
            seen    <= seen | sreg[0];
            cnt     <= cnt + CW'(1);
`ifdef TWOS_DEC_SAT_EN
            // Negative with no one below the sign bit: the most-negative word.
            if (last_c && out_sign && !seen) begin
               out_mag <= {1'b0, {(WIDTH-1){1'b1}}};
               out_sat <= 1'b1;
            end
`else
            out_sat <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_twos_dec_serial.sv
// tb_twos_dec_serial: randomized plus directed bench for twos_dec_serial.
// The reference model works from the signed integer value of each word.
module tb_twos_dec_serial;

   localparam int unsigned WIDTH = 5;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_sign;
   logic [WIDTH-1:0] out_mag;
   logic             out_sat;

   int n_checks = 0;
   int n_fail   = 0;

   twos_dec_serial #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_mag   (out_mag),
      .out_sat   (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: signed value -> absolute value, with optional saturation.
   task automatic model(input logic [WIDTH-1:0] d, output logic s, output logic [WIDTH-1:0] m,
                        output logic sat);
      int v;
      int a;
      v = int'(d);
      if (d[WIDTH-1]) v = v - (1 << WIDTH);
      a = (v < 0) ? -v : v;
      s = (v < 0);
      sat = 1'b0;
`ifdef TWOS_DEC_SAT_EN
      if (a == (1 << (WIDTH-1))) begin
         a = a - 1;
         sat = 1'b1;
      end
`endif
      m = WIDTH'(a);
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      while (!in_ready && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   // One full transaction; hold = cycles of backpressure after out_valid.
   task automatic decode(input logic [WIDTH-1:0] d, input int hold);
      logic             es;
      logic             esat;
      logic [WIDTH-1:0] em;
      int               lat;
      model(d, es, em, esat);
      wait_ready();
      out_ready = (hold == 0);
      in_data   = d;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = ~d;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(WIDTH));
      check("sign", 32'(out_sign), 32'(es));
      check("mag", 32'(out_mag), 32'(em));
      check("sat", 32'(out_sat), 32'(esat));
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom);
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_mag", 32'(out_mag), 32'(em));
            check("bp_sign", 32'(out_sign), 32'(es));
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("hs_valid", 32'(out_valid), 32'd0);
      check("hs_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sign", 32'(out_sign), 32'd0);
      check("rst_mag", 32'(out_mag), 32'd0);
      check("rst_sat", 32'(out_sat), 32'd0);
      rst_n = 1'b1;

      // Directed corners
      decode(5'b11011, 0);
      decode(5'b01011, 0);
      decode(5'b00000, 0);
      decode(5'b11111, 0);
      decode(5'b10000, 0);
      decode(5'b01111, 0);
      decode(5'b00001, 0);
      decode(5'b10000, 10);
      decode(5'b11011, 10);
      decode(5'b11011, 0);

      // Reset during SHIFT with cnt==2
      wait_ready();
      in_data  = 5'b10110;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      check("mid_rst_mag", 32'(out_mag), 32'd0);
      check("mid_rst_sat", 32'(out_sat), 32'd0);
      decode(5'b11011, 0);

      // Randomized words with occasional backpressure
      for (int i = 0; i < 60; i++) begin
         decode(WIDTH'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/twos_dec_serial.md
# twos_dec_serial

Bit-serial two's-complement-to-sign-magnitude decoder for the ALU datapath: it converts signed ALU results back into the sign/magnitude form used by the display and output stage. It takes one WIDTH-bit two's-complement word through a valid/ready handshake. It then walks the word LSB-first, one bit per clock, using the copy-until-first-one-then-invert rule. The result is held in an output register until the consumer accepts it.

## Interface
- WIDTH, 5, operand width in bits; legal range WIDTH ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset; one clock, reset is synchronous and active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  WIDTH  two's-complement operand.
- out_valid  output  1  out_sign/out_mag/out_sat are valid.
- out_ready  input  1  consumer accepts the result.
- out_sign  output  1  sign bit; equals in_data[WIDTH-1].
- out_mag  output  WIDTH  unsigned magnitude.
- out_sat  output  1  most-negative input was saturated; see Configuration.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into shift register sreg, set sign=in_data[WIDTH-1], cnt=0, seen=0, and go to SHIFT.
  - SHIFT: each cycle, process bit b=sreg[0].
    - Magnitude bit = sign ? (b ^ seen) : b.
    - Shift the magnitude bit into the MSB of the mag register, which shifts right.
    - seen ← seen | b.
    - cnt ← cnt+1.
    - When cnt==WIDTH-1, go to DONE.
  - DONE: out_valid=1 and outputs held stable. On out_ready, go to IDLE.
- Positive inputs take the same serial path, so latency is fixed regardless of sign.
- Magnitude never overflows WIDTH bits. The most-negative input, 1 followed by WIDTH-1 zeros, yields magnitude 2^(WIDTH-1).
- in_data changes during SHIFT or DONE are ignored.
- in_valid is not checked outside IDLE.
- No accept in the same cycle as an output handshake: in_ready rises only after returning to IDLE.
- Reset value of every output: in_ready=1, out_valid=0, out_sign=0, out_mag=0, out_sat=0.
  - Internal state after reset: state=IDLE, cnt=0, seen=0.
- Reset asserted in any state, including mid-SHIFT or DONE with out_ready low:
  - The operation is aborted and the result discarded.
  - Reset values apply on the next edge.

## Timing
- Accept edge T puts the FSM in SHIFT.
- Edges T+1 … T+WIDTH process bits 0 … WIDTH-1.
- out_valid is high in the cycle after edge T+WIDTH, so latency is WIDTH cycles from the accept edge.
- Output handshake at edge H, where out_valid&&out_ready are both sampled high:
  - out_valid=0 after H.
  - in_ready=1 after H.
- Maximum throughput is one word per WIDTH+2 cycles.
- out_valid stays high with outputs unchanged for as long as out_ready is low.
- Outputs are registered only. There is no combinational path from in_* to out_*, nor from out_ready to in_ready.

## Configuration
- TWOS_DEC_SAT_EN defined:
  - The most-negative input saturates to out_mag = 2^(WIDTH-1)-1 and sets out_sat=1.
  - The saturation decision is made in the DONE transition using the seen flag and sign.
  - out_sat is held with the other outputs and cleared on the next accept or on reset.
- TWOS_DEC_SAT_EN undefined:
  - The most-negative input gives out_mag = 2^(WIDTH-1).
  - out_sat is tied to 0.
- Latency and handshake behaviour are identical in both builds.

## Test plan
- WIDTH=5, in_data=5'b11011 (-5), out_ready=1:
  - out_valid exactly 5 cycles after the accept edge.
  - out_sign=1, out_mag=5'b00101, out_sat=0.
- in_data=5'b01011 (+11) → out_sign=0, out_mag=5'b01011. in_data=5'b00000 → out_sign=0, out_mag=0.
- in_data=5'b11111 (-1) → out_sign=1, out_mag=5'b00001.
- in_data=5'b10000 (-16):
  - Without macro: out_sign=1, out_mag=5'b10000, out_sat=0.
  - With TWOS_DEC_SAT_EN: out_mag=5'b01111, out_sat=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Outputs stay stable and in_ready stays 0.
  - A new word on in_data is ignored.
  - After out_ready=1, in_ready rises on the next cycle, and a second word (5'b11011) decodes correctly.
- Reset mid-operation: assert rst_n=0 for one cycle during SHIFT (cnt=2).
  - Next cycle: out_valid=0, in_ready=1, out_mag=0.
  - A following word decodes correctly with full latency.
